// File: rtl/trig_rx_decode.sv
`default_nettype none
// ============================================================================
//  Module   : trig_rx_decode
//  Purpose  : Receiver for the scatter-coincidence trigger lines. The block
//             synchronises the asynchronous lines and detects rising edges.
//             It groups edges that fall inside a coincidence window into one
//             event mask and presents that mask on a valid/ready handshake.
//             A dead time follows every accepted event. Saturating per-line
//             counters and a lost-event counter are kept for slow-control
//             readback.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       block clock
//    rst_n      in   1       asynchronous active-low reset
//    trig_in    in   NLINES  asynchronous trigger lines
//    evt_valid  out  1       event mask / timestamp valid
//    evt_ready  in   1       consumer accepts the event when valid & ready
//    evt_mask   out  NLINES  lines that fired inside the window (0 when idle)
//    evt_ts     out  TS_W    timestamp of the first edge (0 when idle)
//    busy       out  1       high while collecting, presenting or in dead time
//    cnt_clr    in   1       synchronous clear of all counters
//    cnt_sel    in   4       0..NLINES-1 line counter, NLINES lost, else 0
//    cnt_val    out  CNT_W   selected counter, registered
//  Build option
//    TRX_TIMESTAMP_EN : when defined, the free-running timestamp counter is
//                       built and evt_ts carries the first-edge time. When it
//                       is undefined, evt_ts is tied to 0.
// ============================================================================
module trig_rx_decode #(
    parameter int NLINES  = 9,
    parameter int WIN     = 4,
    parameter int HOLDOFF = 8,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NLINES-1:0] trig_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [NLINES-1:0] evt_mask,
    output logic [TS_W-1:0]   evt_ts,
    output logic              busy,
    input  logic              cnt_clr,
    input  logic [3:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_val
);

    localparam int              WCNT_W   = $clog2(WIN + 1);
    localparam int              HCNT_W   = $clog2(HOLDOFF + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: two metastability flops plus one delay flop for edges
    // ------------------------------------------------------------------
    logic [NLINES-1:0] sync1_q, sync2_q, sync3_q;
    logic [NLINES-1:0] w_rise;
    logic              w_any_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= trig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign w_rise     = sync2_q & ~sync3_q;
    assign w_any_rise = |w_rise;

    // ------------------------------------------------------------------
    // Event FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [NLINES-1:0]   mask_q, mask_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic                w_handshake;
    logic                w_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        wcnt_d  = wcnt_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_rise) begin
                    mask_d  = w_rise;
                    wcnt_d  = WCNT_W'(WIN - 1);
                    // A one-cycle window has nothing left to collect.
                    state_d = (WIN == 1) ? S_PRESENT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                mask_d = mask_q | w_rise;
                wcnt_d = wcnt_q - WCNT_W'(1);
                if (wcnt_q == WCNT_W'(1)) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (evt_ready) begin
                    if (HOLDOFF == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        hcnt_d  = HCNT_W'(HOLDOFF);
                    end
                end
            end
            S_HOLD: begin
                hcnt_d = hcnt_q - HCNT_W'(1);
                if (hcnt_q == HCNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign evt_valid   = (state_q == S_PRESENT);
    assign busy        = (state_q != S_IDLE);
    assign evt_mask    = evt_valid ? mask_q : '0;
    assign w_handshake = evt_valid & evt_ready;
    // Edges arriving while an event is pending or during dead time are lost.
    assign w_lost      = ((state_q == S_PRESENT) || (state_q == S_HOLD)) & w_any_rise;

    // ------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------
`ifdef TRX_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            ts_evt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if ((state_q == S_IDLE) && w_any_rise) begin
                ts_evt_q <= ts_cnt_q;
            end
        end
    end

    assign evt_ts = evt_valid ? ts_evt_q : '0;
`else
    assign evt_ts = '0;
`endif

    // ------------------------------------------------------------------
    // Saturating counters: index NLINES is the lost-event counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [NLINES+1];
    logic [CNT_W-1:0] w_sel_val;
    logic [CNT_W-1:0] cnt_val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NLINES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_clr) begin
            // Clear takes priority over any increment in the same cycle.
            for (int i = 0; i <= NLINES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NLINES; i++) begin
                if (w_handshake && mask_q[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            if (w_lost && (cnt_q[NLINES] != CNT_MAX)) begin
                cnt_q[NLINES] <= cnt_q[NLINES] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i <= NLINES; i++) begin
            if (cnt_sel == 4'(i)) begin
                w_sel_val = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_val_q <= '0;
        end else begin
            cnt_val_q <= w_sel_val;
        end
    end

    assign cnt_val = cnt_val_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_rx_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trig_rx_decode
//  Purpose  : Self-checking bench for trig_rx_decode. Counter and timestamp
//             widths are reduced so saturation and wrap are reachable in a
//             short run; window and dead time keep their default values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trig_rx_decode;

    localparam int NL      = 9;
    localparam int WIN     = 4;
    localparam int HOLDOFF = 8;
    localparam int CNT_W   = 6;
    localparam int TS_W    = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int TSMOD   = 1 << TS_W;
`ifdef TRX_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NL-1:0]    trig_in = '0;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [NL-1:0]    evt_mask;
    logic [TS_W-1:0]  evt_ts;
    logic             busy;
    logic             cnt_clr = 1'b0;
    logic [3:0]       cnt_sel = '0;
    logic [CNT_W-1:0] cnt_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trig_rx_decode #(
        .NLINES (NL),
        .WIN    (WIN),
        .HOLDOFF(HOLDOFF),
        .CNT_W  (CNT_W),
        .TS_W   (TS_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_in  (trig_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_mask (evt_mask),
        .evt_ts   (evt_ts),
        .busy     (busy),
        .cnt_clr  (cnt_clr),
        .cnt_sel  (cnt_sel),
        .cnt_val  (cnt_val)
    );

    // ------------------------------------------------------------------
    // Reference model, event level: an event opens on the first edge,
    // becomes visible WIN cycles later, and after its handshake the
    // receiver is deaf for HOLDOFF cycles.
    // ------------------------------------------------------------------
    int              cyc = 0;
    bit              have_evt = 0;
    int              present_at = 0;
    int              idle_at = 0;
    logic [NL-1:0]   m_mask = '0;
    int              m_ts = 0;
    int              m_ts_now = 0;
    logic [NL-1:0]   h1 = '0, h2 = '0, h3 = '0;
    int              cnt [NL+1];
    logic            e_valid = 0, e_busy = 0;
    logic [NL-1:0]   e_mask = '0;
    logic [TS_W-1:0] e_ts = '0;
    logic [CNT_W-1:0] e_cnt = '0;

    initial begin
        for (int k = 0; k <= NL; k++) cnt[k] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; have_evt = 0; present_at = 0; idle_at = 0;
                m_mask = '0; m_ts = 0; m_ts_now = 0;
                h1 = '0; h2 = '0; h3 = '0;
                for (int k = 0; k <= NL; k++) cnt[k] = 0;
                e_valid = 0; e_mask = '0; e_ts = '0; e_busy = 0; e_cnt = '0;
            end else begin
                logic [NL-1:0] rise;
                int sel_val;
                // An input high at sample N and low at N-1 is an edge two cycles later.
                rise    = h2 & ~h3;
                sel_val = (int'(cnt_sel) <= NL) ? cnt[cnt_sel] : 0;
                if (!have_evt) begin
                    if (cyc >= idle_at) begin
                        if (rise != 0) begin
                            have_evt   = 1;
                            m_mask     = rise;
                            m_ts       = m_ts_now;
                            present_at = cyc + WIN;
                        end
                    end else if (rise != 0 && cnt[NL] < CMAX) begin
                        cnt[NL]++;
                    end
                end else if (cyc < present_at) begin
                    m_mask = m_mask | rise;
                end else begin
                    if (rise != 0 && cnt[NL] < CMAX) cnt[NL]++;
                    if (evt_ready) begin
                        for (int k = 0; k < NL; k++)
                            if (m_mask[k] && cnt[k] < CMAX) cnt[k]++;
                        have_evt = 0;
                        idle_at  = cyc + 1 + HOLDOFF;
                    end
                end
                if (cnt_clr) for (int k = 0; k <= NL; k++) cnt[k] = 0;
                cyc++;
                m_ts_now = (m_ts_now + 1) % TSMOD;
                h3 = h2; h2 = h1; h1 = trig_in;
                e_valid = have_evt && (cyc >= present_at);
                e_mask  = e_valid ? m_mask : '0;
                e_ts    = (e_valid && TS_EN) ? TS_W'(m_ts) : '0;
                e_busy  = have_evt || (cyc < idle_at);
                e_cnt   = CNT_W'(sel_val);
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            trig_in = '0;
        end
    endtask

    task automatic clear_counters();
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; trig_in = '0; evt_ready = 1'b0; cnt_clr = 1'b0; cnt_sel = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== '0) begin
            errors++;
            $display("FAIL reset: got v%b m%h ts%h b%b c%h, want all 0", evt_valid, evt_mask, evt_ts, busy, cnt_val);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL reset_release: got v%b m%h b%b c%h, want v%b m%h b%b c%h", evt_valid, evt_mask, busy, cnt_val, e_valid, e_mask, e_busy, e_cnt);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        int first_at = -1;
        int nvalid = 0;
        logic [NL-1:0] seen = '0;
        cnt_sel = 4'd0; evt_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL single cyc%0d: got v%b m%h ts%h b%b c%h, want v%b m%h ts%h b%b c%h", i, evt_valid, evt_mask, evt_ts, busy, cnt_val, e_valid, e_mask, e_ts, e_busy, e_cnt);
            end
            if (evt_valid) begin
                nvalid++;
                seen = evt_mask;
                if (first_at < 0) first_at = i;
            end
            trig_in = (i == 0) ? 9'h001 : 9'h000;
        end
        checks++;
        if (first_at !== 6 || nvalid !== 1 || seen !== 9'h001) begin
            errors++;
            $display("FAIL single_latency: got at%0d n%0d m%h, want at6 n1 m001", first_at, nvalid, seen);
        end
        checks++;
        if (cnt_val !== CNT_W'(1)) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", cnt_val);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_window();
        int nvalid = 0;
        logic [NL-1:0] seen = '0;
        logic [NL-1:0] pat;
        clear_counters();
        evt_ready = 1'b1; cnt_sel = 4'd0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL window cyc%0d: got v%b m%h ts%h b%b c%h, want v%b m%h ts%h b%b c%h", i, evt_valid, evt_mask, evt_ts, busy, cnt_val, e_valid, e_mask, e_ts, e_busy, e_cnt);
            end
            if (evt_valid) begin nvalid++; seen = evt_mask; end
            pat = '0;
            if (i == 0) pat[0] = 1'b1;
            if (i == 3) pat[4] = 1'b1;
            if (i == 4) pat[8] = 1'b1;
            trig_in = pat;
            if (i == 16) cnt_sel = 4'd9;
        end
        checks++;
        if (seen !== 9'h011 || nvalid !== 1) begin
            errors++;
            $display("FAIL window_mask: got m%h n%0d, want m011 n1", seen, nvalid);
        end
        checks++;
        if (cnt_val !== CNT_W'(1)) begin
            errors++;
            $display("FAIL window_lost: got %0d want 1", cnt_val);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        bit have_ref = 0;
        int unstable = 0;
        int at2 = -1;
        logic [NL-1:0] ref_mask = '0, seen2 = '0;
        logic [TS_W-1:0] ref_ts = '0;
        logic [NL-1:0] pat;
        idle_cycles(16);
        clear_counters();
        cnt_sel = 4'd9; evt_ready = 1'b0;
        for (int i = 0; i < 52; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL stall cyc%0d: got v%b m%h ts%h b%b c%h, want v%b m%h ts%h b%b c%h", i, evt_valid, evt_mask, evt_ts, busy, cnt_val, e_valid, e_mask, e_ts, e_busy, e_cnt);
            end
            if (evt_valid && i < 30) begin
                if (!have_ref) begin
                    have_ref = 1; ref_mask = evt_mask; ref_ts = evt_ts;
                end else if (evt_mask !== ref_mask || evt_ts !== ref_ts) begin
                    unstable++;
                end
            end
            if (evt_valid && i >= 30 && at2 < 0) begin at2 = i; seen2 = evt_mask; end
            pat = '0;
            if (i == 0) pat[3] = 1'b1;
            if (i == 10 || i == 14 || i == 18) pat[2] = 1'b1;
            if (i == 33) pat[5] = 1'b1;
            trig_in   = pat;
            evt_ready = (i >= 26);
        end
        checks++;
        if (!have_ref || ref_mask !== 9'h008 || unstable !== 0) begin
            errors++;
            $display("FAIL stall_stable: got m%h unstable%0d, want m008 unstable0", ref_mask, unstable);
        end
        checks++;
        if (cnt_val !== CNT_W'(3)) begin
            errors++;
            $display("FAIL stall_lost: got %0d want 3", cnt_val);
        end
        checks++;
        if (at2 !== 39 || seen2 !== 9'h020) begin
            errors++;
            $display("FAIL stall_after_hold: got at%0d m%h, want at39 m020", at2, seen2);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturate();
        idle_cycles(16);
        clear_counters();
        cnt_sel = 4'd1; evt_ready = 1'b1;
        for (int e = 0; e < CMAX + 2; e++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                checks++;
                if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                    errors++;
                    $display("FAIL saturate ev%0d cyc%0d: got v%b m%h b%b c%h, want v%b m%h b%b c%h", e, j, evt_valid, evt_mask, busy, cnt_val, e_valid, e_mask, e_busy, e_cnt);
                end
                trig_in = (j == 0) ? 9'h002 : 9'h000;
            end
        end
        checks++;
        if (cnt_val !== CNT_W'(CMAX)) begin
            errors++;
            $display("FAIL saturate_max: got %0d want %0d", cnt_val, CMAX);
        end
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL saturate_clr cyc%0d: got v%b m%h b%b c%h, want v%b m%h b%b c%h", j, evt_valid, evt_mask, busy, cnt_val, e_valid, e_mask, e_busy, e_cnt);
            end
            trig_in = (j == 0) ? 9'h002 : 9'h000;
            cnt_clr = (j == 6);
        end
        checks++;
        if (cnt_val !== '0) begin
            errors++;
            $display("FAIL saturate_clear_wins: got %0d want 0", cnt_val);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int first_at = -1;
        logic [NL-1:0] seen = '0;
        idle_cycles(16);
        cnt_sel = 4'd9; evt_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: got v%b m%h b%b c%h, want v%b m%h b%b c%h", i, evt_valid, evt_mask, busy, cnt_val, e_valid, e_mask, e_busy, e_cnt);
            end
            trig_in = (i == 0) ? 9'h040 : ((i == 5) ? 9'h008 : 9'h000);
        end
        checks++;
        if (evt_valid !== 1'b1 || cnt_val !== CNT_W'(1)) begin
            errors++;
            $display("FAIL reset_mid_pre: got v%b lost%0d, want v1 lost1", evt_valid, cnt_val);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, evt_mask, busy, cnt_val} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear: got v%b m%h b%b c%h, want all 0", evt_valid, evt_mask, busy, cnt_val);
        end
        @(negedge clk);
        rst_n = 1'b1; evt_ready = 1'b1; cnt_sel = 4'd7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL reset_mid_after cyc%0d: got v%b m%h b%b c%h, want v%b m%h b%b c%h", i, evt_valid, evt_mask, busy, cnt_val, e_valid, e_mask, e_busy, e_cnt);
            end
            if (evt_valid && first_at < 0) begin first_at = i; seen = evt_mask; end
            trig_in = (i == 0) ? 9'h080 : 9'h000;
        end
        checks++;
        if (first_at !== 6 || seen !== 9'h080 || cnt_val !== CNT_W'(1)) begin
            errors++;
            $display("FAIL reset_mid_next: got at%0d m%h c%0d, want at6 m080 c1", first_at, seen, cnt_val);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL random cyc%0d: got v%b m%h ts%h b%b c%h, want v%b m%h ts%h b%b c%h", i, evt_valid, evt_mask, evt_ts, busy, cnt_val, e_valid, e_mask, e_ts, e_busy, e_cnt);
            end
            trig_in   = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
            evt_ready = ($urandom_range(0, 3) != 0);
            cnt_sel   = 4'($urandom_range(0, 15));
            cnt_clr   = ($urandom_range(0, 63) == 0);
        end
        cnt_clr = 1'b0; trig_in = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_ts_wrap();
        bit found = 0;
        logic [TS_W-1:0] ts1 = '1, ts2 = '1;
        evt_ready = 1'b1;
        idle_cycles(20);
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (m_ts_now == TSMOD - 4) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ts_align: timestamp never reached %0d", TSMOD - 4);
        end
        trig_in = 9'h010;
        for (int j = 1; j < 40; j++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid, evt_mask, evt_ts, busy, cnt_val} !== {e_valid, e_mask, e_ts, e_busy, e_cnt}) begin
                errors++;
                $display("FAIL ts cyc%0d: got v%b m%h ts%h b%b, want v%b m%h ts%h b%b", j, evt_valid, evt_mask, evt_ts, busy, e_valid, e_mask, e_ts, e_busy);
            end
            if (evt_valid && j < 16) ts1 = evt_ts;
            if (evt_valid && j >= 16) ts2 = evt_ts;
            trig_in = (j == 16) ? 9'h100 : 9'h000;
        end
        checks++;
        if (ts1 !== (TS_EN ? 8'hFE : 8'h00) || ts2 !== (TS_EN ? 8'h0E : 8'h00)) begin
            errors++;
            $display("FAIL ts_wrap: got %h then %h, want %h then %h", ts1, ts2, TS_EN ? 8'hFE : 8'h00, TS_EN ? 8'h0E : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_window();
        test_stall();
        test_saturate();
        test_reset_mid();
        test_random();
        test_ts_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
